fib_verificador: RTL and testbench
==================================

Name: fib_verificador

Overview:
- Receives the 4-bit Fibonacci stream produced by the team's Fibonacci generator: 0,1,1,2,3,5,8, then wraps to 0, period 7.
- Acquires sequence lock, checks every accepted sample against the expected term, flags mismatches and counts completed periods.
- Sits on the consumer side of the generator output, for self-check and loopback test.

Parameters:
- LARGURA, 4, sample width in bits; the generator wrap rule is generalised to this width.
- LARG_CONT, 8, width of the period and error counters.

Ports:
- clock  input  1  single system clock; all state updates on rising edge.
- resete  input  1  asynchronous, active-low reset (0 = reset asserted).
- entrada_valida  input  1  qualifies entrada; sample accepted on a rising edge with entrada_valida=1.
- entrada  input  LARGURA  received sequence term.
- travado  output  1  1 while locked to the sequence.
- erro  output  1  one-cycle pulse on a mismatch while locked.
- esperado  output  LARGURA  next expected term; valid only while travado=1.
- periodos  output  LARG_CONT  count of complete correct periods (0..8 observed while locked), wraps modulo 2^LARG_CONT.
- erros  output  LARG_CONT  count of mismatches, saturates at all-ones.

Behaviour:
- Reset (resete=0, asynchronous):
  - State BUSCA.
  - Internal pair (A,B) = (1,0).
  - Outputs: travado=0, erro=0, esperado=0, periodos=0, erros=0.
  - Release is synchronous to clock; first sample can be accepted on the first edge after release.
- Expected-term pair follows the generator recurrence. On each accepted correct sample while locked:
  - If B[LARGURA-1]=1: (A,B) <- (1,0).
  - Otherwise: (A,B) <- (A+B mod 2^LARGURA, A).
  - esperado = B.
- State BUSCA:
  - Accepted sample == 0: go to TRAVADO, (A,B) <- (1,1), esperado=1.
  - Any other accepted sample: ignored; stay in BUSCA, no erro.
- State TRAVADO:
  - Accepted sample == esperado: advance pair.
  - If the matched sample had MSB set (the wrap term, 8 for LARGURA=4): periodos increments on the same edge.
  - Accepted sample != esperado: erro=1 for exactly the following cycle; erros increments (saturating); travado falls.
  - Re-acquire after a mismatch: if the mismatching sample is 0, relock immediately to (A,B)=(1,1), travado stays 1 but erro still pulses. Otherwise go to BUSCA.
- entrada_valida=0: no state, pair or counter change; erro forced 0 that cycle.
- Latency: all outputs registered; travado, erro, esperado and counters reflect a sample one edge after acceptance.
- A period counts only if all seven terms 0,1,1,2,3,5,8 were matched in one lock; partial periods before a mismatch never count.
- Reset asserted mid-stream: immediate return to reset values regardless of clock; no erro pulse generated.
- Gaps in entrada_valida of any length are legal and do not break lock.
- Wrap: periodos wraps 255->0; erros holds 255.

Test Plan:
- Reset release, then stream 0,1,1,2,3,5,8 with entrada_valida=1 each cycle:
  - travado=1 from the edge after the 0.
  - esperado sequence 1,1,2,3,5,8,0.
  - periodos=1 after the 8; erro never asserted.
- Stream 3,7,0,1,1,2 from reset:
  - 3 and 7 ignored, erros=0.
  - Lock on the 0, no erro.
- Locked stream 0,1,1,2,4:
  - 4 gives erro pulse for 1 cycle, erros=1, travado=0.
  - Following 0,1 relocks.
- Locked stream 0,1,1,2,0:
  - Mismatch on 0 gives erro pulse, erros=1, travado stays 1, esperado=1.
- Full sequence with entrada_valida toggling 1,0,0,1 between terms:
  - Identical result to the back-to-back case: periodos=1, no erro.
- 256 correct periods then 300 injected mismatches:
  - periodos=0 (wrapped), erros=255.
  - Asserting resete=0 mid-period clears all outputs asynchronously, before the next clock edge.

Source files
------------

// File: rtl/fib_verificador.sv
// Fibonacci stream checker: locks on a 0 term, tracks the expected term pair,
// pulses erro on mismatches, counts complete periods and saturating errors.
module fib_verificador #(
  parameter int unsigned LARGURA   = 4,
  parameter int unsigned LARG_CONT = 8
) (
  input  logic                 clock,
  input  logic                 resete,
  input  logic                 entrada_valida,
  input  logic [LARGURA-1:0]   entrada,
  output logic                 travado,
  output logic                 erro,
  output logic [LARGURA-1:0]   esperado,
  output logic [LARG_CONT-1:0] periodos,
  output logic [LARG_CONT-1:0] erros
);

  typedef enum logic {
    BUSCA   = 1'b0,
    TRAVADO = 1'b1
  } estado_t;

  localparam logic [LARGURA-1:0]   ZERO     = LARGURA'(0);
  localparam logic [LARGURA-1:0]   UM       = LARGURA'(1);
  localparam logic [LARG_CONT-1:0] CONT_UM  = LARG_CONT'(1);
  localparam logic [LARG_CONT-1:0] CONT_MAX = '1;

  estado_t              estado_q, estado_d;
  logic [LARGURA-1:0]   a_q, a_d;
  logic [LARGURA-1:0]   b_q, b_d;
  logic                 erro_q, erro_d;
  logic [LARG_CONT-1:0] periodos_q, periodos_d;
  logic [LARG_CONT-1:0] erros_q, erros_d;

  // b_q is the term expected next; a_q is the one after it.
  always_comb begin
    estado_d   = estado_q;
    a_d        = a_q;
    b_d        = b_q;
    erro_d     = 1'b0;
    periodos_d = periodos_q;
    erros_d    = erros_q;
    if (entrada_valida) begin
      case (estado_q)
        BUSCA: begin
          if (entrada == ZERO) begin
            estado_d = TRAVADO;
            a_d      = UM;
            b_d      = UM;
          end
        end
        TRAVADO: begin
          if (entrada == b_q) begin
            if (b_q[LARGURA-1]) begin
              a_d        = UM;
              b_d        = ZERO;
              periodos_d = periodos_q + CONT_UM;
            end else begin
              a_d = a_q + b_q;
              b_d = a_q;
            end
          end else begin
            erro_d = 1'b1;
            if (erros_q != CONT_MAX) begin
              erros_d = erros_q + CONT_UM;
            end
            // A mismatching 0 is itself a valid lock point.
            if (entrada == ZERO) begin
              a_d = UM;
              b_d = UM;
            end else begin
              estado_d = BUSCA;
              a_d      = UM;
              b_d      = ZERO;
            end
          end
        end
        default: begin
          estado_d = BUSCA;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge resete) begin
    if (!resete) begin
      estado_q   <= BUSCA;
      a_q        <= UM;
      b_q        <= ZERO;
      erro_q     <= 1'b0;
      periodos_q <= '0;
      erros_q    <= '0;
    end else begin
      estado_q   <= estado_d;
      a_q        <= a_d;
      b_q        <= b_d;
      erro_q     <= erro_d;
      periodos_q <= periodos_d;
      erros_q    <= erros_d;
    end
  end

  assign travado  = (estado_q == TRAVADO);
  assign erro     = erro_q;
  assign esperado = b_q;
  assign periodos = periodos_q;
  assign erros    = erros_q;

endmodule

// File: tb/tb_fib_verificador.sv
// Self-checking bench for fib_verificador against a sequence-index reference model.
module tb_fib_verificador;

  logic       clock;
  logic       resete;
  logic       entrada_valida;
  logic [3:0] entrada;
  logic       travado;
  logic       erro;
  logic [3:0] esperado;
  logic [7:0] periodos;
  logic [7:0] erros;

  fib_verificador #(.LARGURA(4), .LARG_CONT(8)) dut (
    .clock          (clock),
    .resete         (resete),
    .entrada_valida (entrada_valida),
    .entrada        (entrada),
    .travado        (travado),
    .erro           (erro),
    .esperado       (esperado),
    .periodos       (periodos),
    .erros          (erros)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;
  string fase = "init";

  // Reference: position within the 7-term period.
  int seq [7] = '{0, 1, 1, 2, 3, 5, 8};
  bit m_locked;
  int m_idx;
  bit m_erro;
  int m_per;
  int m_errs;

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s/%s observed=%0d expected=%0d", fase, tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("travado", int'(travado), int'(m_locked));
    chk("erro", int'(erro), int'(m_erro));
    chk("periodos", int'(periodos), m_per);
    chk("erros", int'(erros), m_errs);
    if (m_locked) chk("esperado", int'(esperado), seq[m_idx]);
  endtask

  task automatic model_reset();
    m_locked = 1'b0;
    m_idx    = 0;
    m_erro   = 1'b0;
    m_per    = 0;
    m_errs   = 0;
  endtask

  task automatic model_update(input logic v, input int d);
    m_erro = 1'b0;
    if (v) begin
      if (!m_locked) begin
        if (d == 0) begin
          m_locked = 1'b1;
          m_idx    = 1;
        end
      end else if (d == seq[m_idx]) begin
        if (m_idx == 6) m_per = (m_per + 1) % 256;
        m_idx = (m_idx + 1) % 7;
      end else begin
        m_erro = 1'b1;
        if (m_errs < 255) m_errs++;
        if (d == 0) m_idx = 1;
        else        m_locked = 1'b0;
      end
    end
  endtask

  task automatic step(input logic v, input int d);
    @(negedge clock);
    entrada_valida = v;
    entrada        = 4'(d);
    @(posedge clock);
    model_update(v, d);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    @(negedge clock);
    resete         = 1'b0;
    entrada_valida = 1'b0;
    entrada        = 4'd0;
    #1;
    model_reset();
    check_all();
    @(negedge clock);
    resete = 1'b1;
  endtask

  int lst [$];
  int d;
  logic v;

  initial begin
    resete         = 1'b0;
    entrada_valida = 1'b0;
    entrada        = 4'd0;
    model_reset();
    #2;
    fase = "reset";
    check_all();
    @(negedge clock);
    resete = 1'b1;

    fase = "full_seq";
    lst = '{0, 1, 1, 2, 3, 5, 8};
    foreach (lst[i]) step(1'b1, lst[i]);
    chk("periodos_one", int'(periodos), 1);

    do_reset();
    fase = "search";
    lst = '{3, 7, 0, 1, 1, 2};
    foreach (lst[i]) step(1'b1, lst[i]);

    do_reset();
    fase = "mismatch";
    lst = '{0, 1, 1, 2, 4, 0, 1};
    foreach (lst[i]) step(1'b1, lst[i]);
    chk("erros_one", int'(erros), 1);

    do_reset();
    fase = "mismatch_zero";
    lst = '{0, 1, 1, 2, 0};
    foreach (lst[i]) step(1'b1, lst[i]);
    chk("relock_esp", int'(esperado), 1);

    do_reset();
    fase = "gaps";
    lst = '{0, 1, 1, 2, 3, 5, 8};
    foreach (lst[i]) begin
      step(1'b1, lst[i]);
      step(1'b0, int'($urandom_range(0, 15)));
      step(1'b0, int'($urandom_range(0, 15)));
    end
    chk("gap_periodos", int'(periodos), 1);

    do_reset();
    fase = "random";
    for (int i = 0; i < 600; i++) begin
      v = ($urandom_range(0, 3) != 0);
      if (m_locked && $urandom_range(0, 9) < 8) d = seq[m_idx];
      else if (!m_locked && $urandom_range(0, 2) == 0) d = 0;
      else d = int'($urandom_range(0, 15));
      step(v, d);
    end

    do_reset();
    fase = "wrap";
    for (int p = 0; p < 256; p++) begin
      for (int t = 0; t < 7; t++) step(1'b1, seq[t]);
    end
    chk("periodos_wrap", int'(periodos), 0);
    for (int i = 0; i < 301; i++) step(1'b1, 0);
    chk("erros_sat", int'(erros), 255);

    fase = "async_reset";
    step(1'b1, 0);
    step(1'b1, 1);
    step(1'b1, 1);
    @(posedge clock);
    #2;
    resete = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clock);
    resete = 1'b1;
    lst = '{0, 1};
    foreach (lst[i]) step(1'b1, lst[i]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
